mem_resp: RTL

Memory responder: the target-side endpoint for the memory controller's request/acknowledge interface. It accepts a read or write command, inserts a fixed number of wait states, performs the access on an internal register-file array, and completes a four-phase req/ack handshake. It sits between the controller's address, data and timing outputs and the storage, and doubles as the bench model for controller verification.

---
 rtl/mem_resp_if.sv | 42 ++++
 rtl/mem_resp.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_resp_if.sv
// mem_resp_if: request/acknowledge bus between a memory controller and the
// mem_resp target.
//
// Handshake (four-phase, level based): the controller raises req_i with
// we_i/addr_i/wdata_i stable and holds them until it sees ack_o high; it then
// drops req_i, and the target drops ack_o one cycle later. A new request is
// only taken once the target is back in its idle state, so req_i must be seen
// low for at least one cycle between transactions. rdata_o is valid while
// ack_o is high for a read. err_o is a one-cycle pulse (abort or bad address).
//
// Signals:
//   req_i    controller -> target  request
//   we_i     controller -> target  1 = write, 0 = read
//   addr_i   controller -> target  word address (AW bits)
//   wdata_i  controller -> target  write data (DW bits)
//   ack_o    target -> controller  acknowledge
//   rdata_o  target -> controller  read data (DW bits)
//   busy_o   target -> controller  transaction in progress
//   err_o    target -> controller  one-cycle error pulse
interface mem_resp_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic          ack_o;
    logic [DW-1:0] rdata_o;
    logic          busy_o;
    logic          err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ack_o, rdata_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ack_o, rdata_o, busy_o, err_o
    );
endinterface

// File: rtl/mem_resp.sv
// mem_resp: target-side memory responder. Accepts a read or write command,
// inserts WAIT_CYC wait states, performs the access on an internal register
// file of DEPTH words and completes a four-phase req/ack handshake.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   bus        mem_resp_if slave modport (req/we/addr/wdata in,
//              ack/rdata/busy/err out), all outputs registered
//   dbg_state  current FSM state (0 = IDLE, 1 = WAIT, 2 = ACK)
module mem_resp #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int DEPTH    = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_resp_if.slave  bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_L  = WAIT_CYC[3:0];
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] mem [DEPTH];

    logic          enter_ack;
    logic          abort;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          in_range;

    // Next state plus the command that the ACK-entry access uses. With zero
    // wait states the access happens on the accept edge itself, so the live
    // bus inputs are used instead of the (not yet loaded) latched copy.
    always_comb begin
        state_nxt = state;
        enter_ack = 1'b0;
        abort     = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state)
            ST_IDLE: begin
                acc_we    = bus.we_i;
                acc_addr  = bus.addr_i;
                acc_wdata = bus.wdata_i;
                if (bus.req_i) begin
                    if (WAIT_L == 4'd0) begin
                        state_nxt = ST_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // A dropped request wins over the final wait cycle.
                if (!bus.req_i) begin
                    state_nxt = ST_IDLE;
                    abort     = 1'b1;
                end else if (cnt == 4'd1) begin
                    state_nxt = ST_ACK;
                    enter_ack = 1'b1;
                end
            end
            ST_ACK: begin
                if (!bus.req_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_range = ({1'b0, acc_addr} < DEPTH_L);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            bus.ack_o   <= 1'b0;
            bus.busy_o  <= 1'b0;
            bus.err_o   <= 1'b0;
            bus.rdata_o <= '0;
        end else begin
            state      <= state_nxt;
            // Outputs follow the next state so they are registered yet
            // line up with the state they describe.
            bus.ack_o  <= (state_nxt == ST_ACK);
            bus.busy_o <= (state_nxt != ST_IDLE);
            bus.err_o  <= abort | (enter_ack & ~in_range);

            if (state == ST_IDLE && bus.req_i) begin
                we_q    <= bus.we_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wdata_i;
                cnt     <= WAIT_L;
            end else if (state == ST_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (enter_ack) begin
                if (!in_range) begin
                    bus.rdata_o <= '0;
                end else if (!acc_we) begin
                    bus.rdata_o <= mem[acc_addr];
                end
            end
        end
    end

    // Storage is not reset; a reset cycle suppresses any pending write.
    always_ff @(posedge clk) begin
        if (rst_n && enter_ack && in_range && acc_we) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

    assign dbg_state = state;

endmodule
